// File: rtl/ring_arb_pkg.sv
// Shared types, defaults and helpers for the ring round-robin arbiter.
package ring_arb_pkg;

  localparam int unsigned N_DEF        = 4;
  localparam int unsigned HOLD_MAX_DEF = 16;
  localparam int unsigned MAX_N        = 32;
  localparam int unsigned MAX_IDW      = $clog2(MAX_N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // One-hot left rotate by one within the low n bits; bit n-1 wraps to bit 0.
  function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int unsigned n);
    logic [MAX_N-1:0] mask;
    mask  = (MAX_N'(1) << n) - MAX_N'(1);
    rotl1 = ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

  function automatic logic [MAX_IDW-1:0] onehot2bin(input logic [MAX_N-1:0] v);
    logic [MAX_IDW-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (v[i]) b = b | MAX_IDW'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/ring_rr_pick.sv
// Combinational round-robin picker: first set req at or above the ptr position, circularly.
module ring_rr_pick
  import ring_arb_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] winner_c,
  output logic         any_c
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] diff;
  logic [2*N-1:0] masked;

  // Subtracting ptr borrows up to the first request at/after ptr; the upper copy handles wrap.
  always_comb begin
    dbl      = {req, req};
    diff     = dbl - {{N{1'b0}}, ptr};
    masked   = dbl & ~diff;
    winner_c = masked[N-1:0] | masked[2*N-1:N];
    any_c    = |req;
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a rotating one-hot token; RING_ARB_TIMEOUT_EN adds a hold timeout.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter  int unsigned N        = N_DEF,
  parameter  int unsigned HOLD_MAX = HOLD_MAX_DEF,
  localparam int unsigned IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   ptr,
  output logic           timeout
);

  if (N < 2 || N > MAX_N || HOLD_MAX < 1) begin : g_cfg_check
    $error("ring_rr_arbiter: unsupported N or HOLD_MAX");
  end

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic           timeout_q, timeout_d;

  logic           owner_done_c, owner_req_c, normal_rel_c, force_rel_c, release_c;
  logic           new_grant_c;
  logic [N-1:0]   pick_ptr_c;
  logic [N-1:0]   winner_c;
  logic           any_c;

  ring_rr_pick #(.N(N)) u_pick (
    .req      (req),
    .ptr      (pick_ptr_c),
    .winner_c (winner_c),
    .any_c    (any_c)
  );

  always_comb begin
    owner_done_c = |(done & gnt_q);
    owner_req_c  = |(req & gnt_q);
    normal_rel_c = (state_q == BUSY) && (owner_done_c || !owner_req_c);
  end

`ifdef RING_ARB_TIMEOUT_EN
  localparam int unsigned HCW = $clog2(HOLD_MAX + 1);
  logic [HCW-1:0] hold_q, hold_d;

  // A normal release on the limit cycle takes precedence and suppresses the timeout pulse.
  always_comb begin
    force_rel_c = (state_q == BUSY) && !normal_rel_c && (hold_q == HCW'(HOLD_MAX - 1));
    hold_d      = hold_q;
    if (new_grant_c)          hold_d = '0;
    else if (state_q == BUSY) hold_d = hold_q + HCW'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  always_comb force_rel_c = 1'b0;
`endif

  // On release the token moves one past the owner, so a still-requesting owner ranks last.
  always_comb begin
    release_c  = normal_rel_c || force_rel_c;
    pick_ptr_c = release_c ? N'(rotl1(MAX_N'(gnt_q), N)) : ptr_q;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    timeout_d   = 1'b0;
    new_grant_c = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (any_c) begin
          gnt_d       = winner_c;
          state_d     = BUSY;
          new_grant_c = 1'b1;
        end
      end
      BUSY: begin
        if (release_c) begin
          ptr_d       = pick_ptr_c;
          timeout_d   = force_rel_c;
          new_grant_c = any_c;
          if (any_c) begin
            gnt_d = winner_c;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    gnt_valid_d = |gnt_d;
    gnt_id_d    = IDW'(onehot2bin(MAX_N'(gnt_d)));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      ptr_q       <= N'(1);
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign ptr       = ptr_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed self-checking bench for ring_rr_arbiter (N=4, HOLD_MAX=4); honours RING_ARB_TIMEOUT_EN.
module tb_ring_rr_arbiter;

  logic       clk;
  logic       clr;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [3:0] ptr;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  ring_rr_arbiter #(.N(4), .HOLD_MAX(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .ptr       (ptr),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    tick();
    tick();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({gnt, ptr, gnt_id, gnt_valid, timeout} !== {4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d gnt=%b ptr=%b id=%0d valid=%b tmo=%b, want 0000 0001 0 0 0",
                 i, gnt, ptr, gnt_id, gnt_valid, timeout);
      end
      tick();
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    tick();
    checks++;
    if ({gnt, gnt_id, gnt_valid, ptr} !== {4'b0100, 2'd2, 1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL single_grant gnt=%b id=%0d valid=%b ptr=%b, want 0100 2 1 0001", gnt, gnt_id, gnt_valid, ptr);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL single_hold gnt=%b, want 0100", gnt);
    end
    req  = 4'b0000;
    done = 4'b0100;
    tick();
    done = 4'b0000;
    checks++;
    if ({gnt, gnt_valid, gnt_id, ptr} !== {4'b0000, 1'b0, 2'd0, 4'b1000}) begin
      errors++;
      $display("FAIL single_release gnt=%b valid=%b id=%0d ptr=%b, want 0000 0 0 1000", gnt, gnt_valid, gnt_id, ptr);
    end
    done = 4'b0010;
    tick();
    done = 4'b0000;
    checks++;
    if ({gnt, ptr} !== {4'b0000, 4'b1000}) begin
      errors++;
      $display("FAIL idle_done_ignored gnt=%b ptr=%b, want 0000 1000", gnt, ptr);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    do_clr();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({gnt, gnt_valid, gnt_id, ptr} !== {exp, 1'b1, 2'(k % 4), exp}) begin
          errors++;
          $display("FAIL rotation k=%0d c=%0d gnt=%b valid=%b id=%0d ptr=%b, want %b 1 %0d %b",
                   k, c, gnt, gnt_valid, gnt_id, ptr, exp, k % 4, exp);
        end
        if (c == 2) done = exp;
        tick();
        done = 4'b0000;
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if ({gnt, gnt_valid, ptr} !== {4'b0000, 1'b0, 4'b0100}) begin
      errors++;
      $display("FAIL req_drop_release gnt=%b valid=%b ptr=%b, want 0000 0 0100", gnt, gnt_valid, ptr);
    end
  endtask

  task automatic test_simultaneous();
    do_clr();
    req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL simul_setup gnt=%b, want 0010", gnt);
    end
    req  = 4'b0101;
    done = 4'b1010;
    tick();
    done = 4'b0000;
    checks++;
    if ({gnt, gnt_id, ptr} !== {4'b0100, 2'd2, 4'b0100}) begin
      errors++;
      $display("FAIL simul_switch gnt=%b id=%0d ptr=%b, want 0100 2 0100", gnt, gnt_id, ptr);
    end
    req  = 4'b1101;
    done = 4'b1000;
    tick();
    tick();
    done = 4'b0000;
    checks++;
    if ({gnt, ptr} !== {4'b0100, 4'b0100}) begin
      errors++;
      $display("FAIL stray_done gnt=%b ptr=%b, want 0100 0100", gnt, ptr);
    end
  endtask

  task automatic test_clr_mid();
    do_clr();
    req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL clr_mid_setup gnt=%b, want 0010", gnt);
    end
    clr = 1'b1;
    req = 4'b1111;
    tick();
    clr = 1'b0;
    checks++;
    if ({gnt, gnt_valid, gnt_id, ptr} !== {4'b0000, 1'b0, 2'd0, 4'b0001}) begin
      errors++;
      $display("FAIL clr_mid gnt=%b valid=%b id=%0d ptr=%b, want 0000 0 0 0001", gnt, gnt_valid, gnt_id, ptr);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL clr_regrant gnt=%b, want 0001", gnt);
    end
  endtask

  task automatic test_timeout();
    do_clr();
    req = 4'b0011;
    tick();
`ifdef RING_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({gnt, timeout} !== {4'b0001, 1'b0}) begin
        errors++;
        $display("FAIL tmo_hold cyc=%0d gnt=%b tmo=%b, want 0001 0", i, gnt, timeout);
      end
      tick();
    end
    checks++;
    if ({gnt, timeout, ptr} !== {4'b0010, 1'b1, 4'b0010}) begin
      errors++;
      $display("FAIL tmo_fire gnt=%b tmo=%b ptr=%b, want 0010 1 0010", gnt, timeout, ptr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({gnt, timeout} !== {4'b0010, 1'b0}) begin
        errors++;
        $display("FAIL tmo_pulse_len cyc=%0d gnt=%b tmo=%b, want 0010 0", i, gnt, timeout);
      end
    end
    done = 4'b0010;
    tick();
    done = 4'b0000;
    checks++;
    if ({gnt, timeout, ptr} !== {4'b0001, 1'b0, 4'b0100}) begin
      errors++;
      $display("FAIL tmo_done_wins gnt=%b tmo=%b ptr=%b, want 0001 0 0100", gnt, timeout, ptr);
    end
`else
    for (int i = 0; i < 50; i++) begin
      checks++;
      if ({gnt, timeout, ptr} !== {4'b0001, 1'b0, 4'b0001}) begin
        errors++;
        $display("FAIL no_tmo cyc=%0d gnt=%b tmo=%b ptr=%b, want 0001 0 0001", i, gnt, timeout, ptr);
      end
      tick();
    end
`endif
    req = 4'b0000;
    tick();
  endtask

  initial begin
    clr  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_simultaneous();
    test_clr_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
